// File: rtl/cpu_mem_loader_if.sv
// Load stream, dump stream and the two CPU external memory ports driven by cpu_mem_loader.
// master = loader side, slave = stream source/sink plus the CPU memories.
interface cpu_mem_loader_if;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;

    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;

    logic [63:0] addr_ext;
    logic        wen_ext;
    logic        ren_ext;
    logic [31:0] wdata_ext;

    logic [63:0] addr_ext_2;
    logic        wen_ext_2;
    logic        ren_ext_2;
    logic [63:0] wdata_ext_2;
    logic [63:0] rdata_ext_2;

    modport master (
        input  in_valid, in_data, out_ready, rdata_ext_2,
        output in_ready, out_valid, out_data,
               addr_ext, wen_ext, ren_ext, wdata_ext,
               addr_ext_2, wen_ext_2, ren_ext_2, wdata_ext_2
    );

    modport slave (
        output in_valid, in_data, out_ready, rdata_ext_2,
        input  in_ready, out_valid, out_data,
               addr_ext, wen_ext, ren_ext, wdata_ext,
               addr_ext_2, wen_ext_2, ren_ext_2, wdata_ext_2
    );
endinterface

// File: rtl/cpu_mem_loader.sv
// Loads instruction/data memory from a stream, runs the CPU for a set number of cycles,
// then streams a window of data memory back out.
module cpu_mem_loader #(
    parameter int IMEM_DEPTH = 512,
    parameter int DMEM_DEPTH = 1024,
    parameter int CYCLE_W    = 32
) (
    input  logic                          clk,
    input  logic                          arst,
    input  logic                          start_i,
    input  logic [$clog2(IMEM_DEPTH):0]   imem_count_i,
    input  logic [$clog2(DMEM_DEPTH):0]   dmem_count_i,
    input  logic [CYCLE_W-1:0]            run_cycles_i,
    input  logic [$clog2(DMEM_DEPTH):0]   dump_count_i,
    output logic                          busy_o,
    output logic                          done_o,
    output logic                          cpu_enable_o,
    cpu_mem_loader_if.master              bus
);
    localparam int IW = $clog2(IMEM_DEPTH) + 1;
    localparam int DW = $clog2(DMEM_DEPTH) + 1;
    localparam int XW = (DW > IW) ? DW : IW;

    typedef enum logic [2:0] {IDLE, LOAD_I, LOAD_D, RUN, DUMP, DONE} state_t;

    state_t            state_q, start_state_d, after_i_d, after_d_d, after_r_d;
    logic [IW-1:0]     icnt_q, icnt_d;
    logic [DW-1:0]     dcnt_q, dcnt_d, ucnt_q, ucnt_d;
    logic [CYCLE_W-1:0] run_q;
    logic [XW-1:0]     idx_q, idx_d;
    logic              inflight_q, out_valid_q, cpu_enable_q;
    logic [63:0]       out_data_q;
    logic              wen_i, wen_d, ren_d, last_i, last_d, last_u;
    logic [63:0]       idx_64;

    // First non-empty phase in load/run/dump order; everything empty means DONE.
    function automatic state_t first_phase(input logic has_i, input logic has_d,
                                           input logic has_r, input logic has_u);
        if (has_i) return LOAD_I;
        if (has_d) return LOAD_D;
        if (has_r) return RUN;
        if (has_u) return DUMP;
        return DONE;
    endfunction

    always_comb begin
        icnt_d = (imem_count_i > IW'(IMEM_DEPTH)) ? IW'(IMEM_DEPTH) : imem_count_i;
        dcnt_d = (dmem_count_i > DW'(DMEM_DEPTH)) ? DW'(DMEM_DEPTH) : dmem_count_i;
        ucnt_d = (dump_count_i > DW'(DMEM_DEPTH)) ? DW'(DMEM_DEPTH) : dump_count_i;
        start_state_d = first_phase(icnt_d != '0, dcnt_d != '0, run_cycles_i != '0, ucnt_d != '0);
        after_i_d = first_phase(1'b0, dcnt_q != '0, run_q != '0, ucnt_q != '0);
        after_d_d = first_phase(1'b0, 1'b0, run_q != '0, ucnt_q != '0);
        after_r_d = first_phase(1'b0, 1'b0, 1'b0, ucnt_q != '0);
        idx_d  = idx_q + XW'(1);
        last_i = (idx_d == XW'(icnt_q));
        last_d = (idx_d == XW'(dcnt_q));
        last_u = (idx_d == XW'(ucnt_q));
    end

    assign wen_i  = (state_q == LOAD_I) && bus.in_valid;
    assign wen_d  = (state_q == LOAD_D) && bus.in_valid;
    assign ren_d  = (state_q == DUMP) && !inflight_q && !out_valid_q;
    assign idx_64 = {{(64-XW){1'b0}}, idx_q};

    assign bus.in_ready    = (state_q == LOAD_I) || (state_q == LOAD_D);
    assign bus.wen_ext     = wen_i;
    assign bus.ren_ext     = 1'b0;
    assign bus.addr_ext    = wen_i ? (idx_64 << 2) : '0;
    assign bus.wdata_ext   = wen_i ? bus.in_data[31:0] : '0;
    assign bus.wen_ext_2   = wen_d;
    assign bus.ren_ext_2   = ren_d;
    assign bus.addr_ext_2  = (wen_d || ren_d) ? (idx_64 << 3) : '0;
    assign bus.wdata_ext_2 = wen_d ? bus.in_data : '0;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_data    = out_data_q;

    assign busy_o       = (state_q == LOAD_I) || (state_q == LOAD_D) ||
                          (state_q == RUN) || (state_q == DUMP);
    assign done_o       = (state_q == DONE);
    assign cpu_enable_o = cpu_enable_q;

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q      <= IDLE;
            icnt_q       <= '0;
            dcnt_q       <= '0;
            ucnt_q       <= '0;
            run_q        <= '0;
            idx_q        <= '0;
            inflight_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            cpu_enable_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start_i) begin
                        icnt_q       <= icnt_d;
                        dcnt_q       <= dcnt_d;
                        ucnt_q       <= ucnt_d;
                        run_q        <= run_cycles_i;
                        idx_q        <= '0;
                        state_q      <= start_state_d;
                        cpu_enable_q <= (start_state_d == RUN);
                    end
                end
                LOAD_I: begin
                    if (bus.in_valid) begin
                        if (last_i) begin
                            idx_q        <= '0;
                            state_q      <= after_i_d;
                            cpu_enable_q <= (after_i_d == RUN);
                        end else begin
                            idx_q <= idx_d;
                        end
                    end
                end
                LOAD_D: begin
                    if (bus.in_valid) begin
                        if (last_d) begin
                            idx_q        <= '0;
                            state_q      <= after_d_d;
                            cpu_enable_q <= (after_d_d == RUN);
                        end else begin
                            idx_q <= idx_d;
                        end
                    end
                end
                RUN: begin
                    // Terminal count at 1 so enable is high for exactly run_cycles edges.
                    if (run_q == CYCLE_W'(1)) begin
                        state_q      <= after_r_d;
                        cpu_enable_q <= 1'b0;
                    end else begin
                        run_q <= run_q - CYCLE_W'(1);
                    end
                end
                DUMP: begin
                    if (ren_d) inflight_q <= 1'b1;
                    if (inflight_q) begin
                        inflight_q  <= 1'b0;
                        out_valid_q <= 1'b1;
                        out_data_q  <= bus.rdata_ext_2;
                    end
                    if (out_valid_q && bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        if (last_u) begin
                            idx_q   <= '0;
                            state_q <= DONE;
                        end else begin
                            idx_q <= idx_d;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/cpu_mem_loader.md
# cpu_mem_loader

Host-side loader that drives the CPU's external memory ports. It streams a program into instruction memory and initial data into data memory over a valid/ready input stream. It then asserts the CPU `enable` for a programmed number of cycles and streams a window of data memory back out over a valid/ready output stream. It sits outside `cpu` in the test harness/SoC top and is the only master of `addr_ext*`/`wen_ext*`/`ren_ext*`/`wdata_ext*`.

## Interface
- `IMEM_DEPTH`, 512: instruction memory depth in 32-bit words.
- `DMEM_DEPTH`, 1024: data memory depth in 64-bit words.
- `CYCLE_W`, 32: width of the run-cycle counter.

Ports:
- `clk` in 1: single clock for the block and the CPU.
- `arst` in 1: reset, asynchronous, active-high.
- `start` in 1: begin a load/run/dump sequence; sampled only in IDLE or DONE.
- `imem_count` in $clog2(IMEM_DEPTH)+1: instruction words to load.
- `dmem_count` in $clog2(DMEM_DEPTH)+1: data words to load.
- `run_cycles` in CYCLE_W: cycles to hold `cpu_enable` high.
- `dump_count` in $clog2(DMEM_DEPTH)+1: data words to read back, starting at word 0.
- `in_valid` in 1, `in_ready` out 1, `in_data` in 64: load stream. Instruction words use `in_data[31:0]`.
- `out_valid` out 1, `out_ready` in 1, `out_data` out 64: dump stream.
- `busy` out 1: high in LOAD_I, LOAD_D, RUN, DUMP.
- `done` out 1: high in DONE.
- `cpu_enable` out 1: drives `cpu.enable`.
- `addr_ext` out 64, `wen_ext` out 1, `ren_ext` out 1, `wdata_ext` out 32: instruction memory external port.
- `addr_ext_2` out 64, `wen_ext_2` out 1, `ren_ext_2` out 1, `wdata_ext_2` out 64, `rdata_ext_2` in 64: data memory external port.

## Operation
- **States**: IDLE, LOAD_I, LOAD_D, RUN, DUMP, DONE.
- **Start**:
  - In IDLE or DONE, `start` latches all four counts and clears `done`.
  - Counts above the depth are clamped to the depth.
  - `start` in any other state is ignored.
- **Entry and skipping**: the next state is the first of LOAD_I, LOAD_D, RUN, DUMP whose count is non-zero. If all counts are zero, go straight to DONE.
- **LOAD_I**:
  - `in_ready`=1.
  - On each handshake, in the same cycle (combinational): `wen_ext`=1, `addr_ext`=idx*4, `wdata_ext`=`in_data[31:0]`, then idx++.
  - The handshake on word `imem_count`-1 moves to the next non-zero phase.
- **LOAD_D**: same as LOAD_I on port 2, with `addr_ext_2`=idx*8 and `wdata_ext_2`=`in_data`.
- **RUN**:
  - `cpu_enable`=1 (registered) for exactly `run_cycles` consecutive cycles.
  - It falls on the edge that enters the next state.
  - All ext strobes are 0.
- **DUMP**: 1-entry output register plus an in-flight flag.
  - Issue a read (`ren_ext_2`=1, `addr_ext_2`=idx*8) in a cycle when no read is in flight and `out_valid`=0.
  - `rdata_ext_2` is valid in the following cycle, captured at its end; `out_valid` rises.
  - `out_data`/`out_valid` hold until `out_ready`.
  - After the handshake of word `dump_count`-1, go to DONE.
- **DONE**: `done`=1 level, held until the next `start` or reset.
- **Idle port values**: `ren_ext` is tied 0. Whenever a port is not being strobed, its address/wdata are 0 and its strobes are 0.
- **In-flight read at reset**: an in-flight read is discarded if reset occurs.
- **Index counters**: sized to count to depth without wrap. Address arithmetic is zero-extended to 64 bits.

## Timing
- **Reset**: `arst` forces IDLE immediately (asynchronously), regardless of state. All outputs are 0, including `cpu_enable`, `in_ready` and `out_valid`. Indices and counters are cleared.
- **Load throughput**: one word per cycle with back-to-back `in_valid`. The write commits on the handshake edge.
- **Dump throughput**: at most one word per 3 cycles (read, capture, handshake). Minimum latency from DUMP entry to `out_valid` is 2 cycles.
- **No overlap**: `cpu_enable` is never high in the same cycle as any ext strobe.
- **Stalls**:
  - `in_valid` low stalls LOAD_I/LOAD_D indefinitely.
  - `out_ready` low stalls DUMP indefinitely, with `out_data` stable.
- **Simultaneous events**: `start` and `arst` together means reset wins. `start` in DONE restarts the sequence on the next edge.

## Test plan
- **Full sequence**: counts 3/2/10/2; instruction words A,B,C; data words D0,D1; run 10.
  - Instruction memory writes at 0x0, 0x4, 0x8 and data memory writes at 0x0, 0x8.
  - `cpu_enable` is high exactly 10 cycles.
  - `out_data` returns the data memory contents at 0x0 then 0x8.
  - `done`=1.
- **Backpressure**: `in_valid` toggled every other cycle during load, and `out_ready` held low 5 cycles on the first dump word.
  - No dropped or duplicated writes.
  - `out_data` stable while stalled.
- **Zero counts**: counts 0/0/0/1 go IDLE -> DUMP -> DONE with one read at address 0 and no `cpu_enable`. All counts zero gives `done` 1 cycle after `start`.
- **Clamp**: `imem_count`=600 results in exactly 512 writes, with the last at address 0x7FC.
- **Reset mid-operation**: assert `arst` during RUN and in DUMP with a read in flight.
  - `cpu_enable`, `out_valid`, `busy` are 0 immediately.
  - A subsequent `start` runs a clean sequence.
- **Start while busy**: `start` pulsed during LOAD_D is ignored, and the sequence completes with the original counts.
